// File: rtl/spi_tx_pkg.sv
// Shared definitions for the SPI master transmit engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding and default word / divider widths.
package spi_tx_pkg;

    // Default word width (also the TX FIFO data width) and divider width.
    localparam int SPI_TX_DATA_W = 8;
    localparam int SPI_TX_DIV_W  = 8;

    // Transmit FSM. A word walks IDLE -> SETUP -> SHIFT -> GAP -> IDLE;
    // with back-to-back words enabled, SHIFT can loop onto itself.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } spi_tx_state_t;

endpackage

// File: rtl/spi_tx_clkgen.sv
// SCK phase timer: counts one SCK half-period and emits a tick on its last cycle.
// Latency: first tick div+1 cycles after start, then every div+1 cycles while running.
// Backpressure: none; start wins over stop, stop parks the counter until the next start.
//
// Ports:
//   CLK, RESETn  clock, asynchronous active-low reset
//   start        load the counter with div and begin running
//   stop         halt and clear the counter
//   div          half-period setting minus one (reloaded at every tick)
//   tick         high on the last cycle of each half-period
module spi_tx_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic             run_q;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            cnt_q <= div;
            run_q <= 1'b1;
        end else if (stop) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (run_q) begin
            // Reload at every phase edge so each phase is exactly div+1 cycles.
            cnt_q <= (cnt_q == '0) ? div : cnt_q - 1'b1;
        end
    end

    assign tick = run_q && (cnt_q == '0);

endmodule

// File: rtl/spi_tx_shifter.sv
// SPI mode-0 master transmitter: pops one FIFO word and shifts it out MSB-first on SCK/MOSI/CS_n.
// Latency: pop cycle, then H setup cycles, 2*DATA_W*H shift cycles, H gap cycles (H = clk_div+1).
// Backpressure: pops only when en && !fifo_tx_empty in IDLE (or at the word boundary in burst mode).
//
// Ports:
//   CLK, RESETn       system clock, asynchronous active-low reset
//   en                transmit enable; dropping it lets the current word finish
//   clk_div           SCK half-period minus one, latched in the pop cycle
//   fifo_tx_empty     TX FIFO empty flag
//   fifo_tx_data_out  show-ahead FIFO head
//   fifo_tx_read      one-cycle pop strobe (combinational, same cycle as the capture)
//   SCK, MOSI, CS_n   SPI bus, SCK idles low, CS_n active low
//   busy              high from the pop cycle until the FSM is back in IDLE
//   done              one-cycle pulse per completed word
//
// Build option: define SPI_TX_BURST_EN to chain queued words inside one CS_n window
// (the next word is popped in the last cycle of the final low phase, SCK stays periodic).
module spi_tx_shifter
    import spi_tx_pkg::*;
#(
    parameter int DATA_W = SPI_TX_DATA_W,
    parameter int DIV_W  = SPI_TX_DIV_W
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              en,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              fifo_tx_empty,
    input  logic [DATA_W-1:0] fifo_tx_data_out,
    output logic              fifo_tx_read,
    output logic              SCK,
    output logic              MOSI,
    output logic              CS_n,
    output logic              busy,
    output logic              done
);

    localparam int              CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] BITS  = CNT_W'(DATA_W);

    spi_tx_state_t     state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_shl;
    logic [CNT_W-1:0]  bit_cnt_q;     // bits whose high phase is still to come
    logic [DIV_W-1:0]  div_q;
    logic              sck_q;
    logic              mosi_q;
    logic              cs_n_q;
    logic              done_q;

    logic              tick;
    logic              can_pop;
    logic              idle_pop;
    logic              burst_pop;
    logic [DIV_W-1:0]  gen_div;
    logic              gen_stop;

    // RESETn gates the strobe so nothing is popped while reset is held.
    assign can_pop  = RESETn && en && !fifo_tx_empty;
    assign idle_pop = can_pop && (state_q == ST_IDLE);

`ifdef SPI_TX_BURST_EN
    // Last cycle of the final low phase of the current word.
    assign burst_pop = can_pop && (state_q == ST_SHIFT) && !sck_q
                       && (bit_cnt_q == '0) && tick;
`else
    assign burst_pop = 1'b0;
`endif

    assign fifo_tx_read = idle_pop || burst_pop;

    // The divider is latched in the pop cycle; the phase timer must already
    // use the new value then, hence the bypass around div_q.
    assign gen_div  = fifo_tx_read ? clk_div : div_q;
    assign gen_stop = (state_q == ST_GAP) && tick;

    spi_tx_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .CLK    (CLK),
        .RESETn (RESETn),
        .start  (fifo_tx_read),
        .stop   (gen_stop),
        .div    (gen_div),
        .tick   (tick)
    );

    assign shreg_shl = shreg_q << 1;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (idle_pop) begin
                        state_q   <= ST_SETUP;
                        shreg_q   <= fifo_tx_data_out;
                        div_q     <= clk_div;
                        bit_cnt_q <= BITS;
                        cs_n_q    <= 1'b0;
                        mosi_q    <= fifo_tx_data_out[DATA_W-1];
                        sck_q     <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    if (tick) begin
                        state_q <= ST_SHIFT;
                        sck_q   <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (tick) begin
                        if (sck_q) begin
                            // Falling edge: present the next bit, but hold the
                            // last bit through the final low phase.
                            sck_q     <= 1'b0;
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                            if (bit_cnt_q != CNT_W'(1)) begin
                                shreg_q <= shreg_shl;
                                mosi_q  <= shreg_shl[DATA_W-1];
                            end
                        end else if (bit_cnt_q != '0) begin
                            sck_q <= 1'b1;
                        end else if (burst_pop) begin
                            // Chain the next word straight into its first high phase.
                            shreg_q   <= fifo_tx_data_out;
                            div_q     <= clk_div;
                            bit_cnt_q <= BITS;
                            mosi_q    <= fifo_tx_data_out[DATA_W-1];
                            sck_q     <= 1'b1;
                        end else begin
                            state_q <= ST_GAP;
                            cs_n_q  <= 1'b1;
                            mosi_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                ST_GAP: begin
                    if (tick) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign SCK  = sck_q;
    assign MOSI = mosi_q;
    assign CS_n = cs_n_q;
    assign busy = (state_q != ST_IDLE) || fifo_tx_read;
    // In burst mode a chained word completes in its successor's pop cycle.
    assign done = done_q || burst_pop;

endmodule

// File: tb/tb_spi_tx_shifter.sv
// Self-checking bench for spi_tx_shifter: per-cycle comparison against a formula-based
// model of the SPI waveform, plus per-test literal totals (pulse counts, window lengths, bits).
// Build with or without SPI_TX_BURST_EN; expectations follow the same macro.
module tb_spi_tx_shifter;

    localparam int DW = 8;
    localparam int VW = 8;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          en = 1'b0;
    logic [VW-1:0] clk_div = '0;
    logic          fifo_tx_empty = 1'b1;
    logic [DW-1:0] fifo_tx_data_out = '0;
    logic          fifo_tx_read, SCK, MOSI, CS_n, busy, done;

    spi_tx_shifter #(.DATA_W(DW), .DIV_W(VW)) dut (
        .CLK              (CLK),
        .RESETn           (RESETn),
        .en               (en),
        .clk_div          (clk_div),
        .fifo_tx_empty    (fifo_tx_empty),
        .fifo_tx_data_out (fifo_tx_data_out),
        .fifo_tx_read     (fifo_tx_read),
        .SCK              (SCK),
        .MOSI             (MOSI),
        .CS_n             (CS_n),
        .busy             (busy),
        .done             (done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- show-ahead FIFO ----------------
    logic [DW-1:0] fifo_q[$];
    logic          pop_seen = 1'b0;

    task automatic fifo_refresh();
        fifo_tx_empty    = (fifo_q.size() == 0);
        fifo_tx_data_out = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        fifo_refresh();
    endtask

    always begin
        @(posedge CLK);
        #1;
        if (pop_seen && fifo_q.size() > 0) begin
            fifo_q.delete(0);
            fifo_refresh();
        end
    end

    // ---------------- waveform model ----------------
    // Cycle t counts from the pop cycle (t=0). H setup cycles, then 2*DW phases
    // of H cycles (high first), then one done/CS_n-high cycle opening an H-cycle gap.
    task automatic word_out(input int t, input int h, input logic [DW-1:0] w,
                            output logic sck, output logic mosi,
                            output logic cs, output logic dn);
        int u, p, k;
        sck = 1'b0; mosi = 1'b0; cs = 1'b1; dn = 1'b0;
        if (t <= h) begin
            cs = 1'b0;
            mosi = w[DW-1];
        end else if (t <= (2*DW+1)*h) begin
            u = t - h - 1;
            p = u / h;
            k = p / 2;
            cs = 1'b0;
            sck = (p % 2 == 0);
            if (sck)          mosi = w[DW-1-k];
            else if (k < DW-1) mosi = w[DW-2-k];
            else              mosi = w[0];
        end else if (t == (2*DW+1)*h + 1) begin
            dn = 1'b1;
        end
    endtask

    int            m_active = 0;
    int            m_t = 0;
    int            m_h = 1;
    logic [DW-1:0] m_w = '0;
    logic          e_read, e_sck, e_mosi, e_cs, e_busy, e_done;

    // Monitors for per-test literal totals.
    int            mon_cs_low, mon_cs_win, mon_rises, mon_sck_hi, mon_reads, mon_done, mon_busy;
    logic [31:0]   mon_bits;
    logic          sck_prev = 1'b0;
    logic          cs_prev = 1'b1;

    task automatic mon_clear();
        mon_cs_low = 0; mon_cs_win = 0; mon_rises = 0; mon_sck_hi = 0;
        mon_reads = 0; mon_done = 0; mon_busy = 0; mon_bits = '0;
    endtask

    always @(negedge CLK) begin
        e_read = 1'b0; e_sck = 1'b0; e_mosi = 1'b0; e_cs = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        if (!RESETn) begin
            m_active = 0;
        end else if (m_active == 0) begin
            if (en && !fifo_tx_empty) begin
                e_read = 1'b1;
                e_busy = 1'b1;
                m_active = 1;
                m_t = 1;
                m_h = int'(clk_div) + 1;
                m_w = fifo_tx_data_out;
            end
        end else begin
            e_busy = 1'b1;
            word_out(m_t, m_h, m_w, e_sck, e_mosi, e_cs, e_done);
            if (m_t == (2*DW+2)*m_h) begin
                m_active = 0;
            end
`ifdef SPI_TX_BURST_EN
            else if (m_t == (2*DW+1)*m_h && en && !fifo_tx_empty) begin
                e_read = 1'b1;
                e_done = 1'b1;
                m_h = int'(clk_div) + 1;
                m_w = fifo_tx_data_out;
                m_t = m_h + 1;
            end
`endif
            else begin
                m_t++;
            end
        end

        chk("cyc_read", {31'd0, fifo_tx_read}, {31'd0, e_read});
        chk("cyc_sck",  {31'd0, SCK},          {31'd0, e_sck});
        chk("cyc_mosi", {31'd0, MOSI},         {31'd0, e_mosi});
        chk("cyc_cs_n", {31'd0, CS_n},         {31'd0, e_cs});
        chk("cyc_busy", {31'd0, busy},         {31'd0, e_busy});
        chk("cyc_done", {31'd0, done},         {31'd0, e_done});

        if (CS_n === 1'b0) mon_cs_low++;
        if (CS_n === 1'b0 && cs_prev === 1'b1) mon_cs_win++;
        if (SCK === 1'b1 && sck_prev === 1'b0) begin
            mon_rises++;
            mon_bits = {mon_bits[30:0], MOSI};
        end
        if (SCK === 1'b1) mon_sck_hi++;
        if (fifo_tx_read === 1'b1) mon_reads++;
        if (done === 1'b1) mon_done++;
        if (busy === 1'b1) mon_busy++;
        sck_prev = SCK;
        cs_prev  = CS_n;
        pop_seen = fifo_tx_read;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int i;
        i = 0;
        cyc(1);
        while (!(busy === 1'b0 && !(en && !fifo_tx_empty)) && i < budget) begin
            cyc(1);
            i++;
        end
        chk(nm, {31'd0, (busy === 1'b0)}, 32'd1);
    endtask

    task automatic wait_rises(input string nm, input int n, input int budget);
        int i;
        i = 0;
        while (mon_rises < n && i < budget) begin
            cyc(1);
            i++;
        end
        chk(nm, {31'd0, (mon_rises >= n)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        mon_clear();
        RESETn = 1'b0;
        cyc(3);
        chk("rst_read", {31'd0, fifo_tx_read}, 32'd0);
        chk("rst_sck",  {31'd0, SCK},          32'd0);
        chk("rst_mosi", {31'd0, MOSI},         32'd0);
        chk("rst_cs_n", {31'd0, CS_n},         32'd1);
        chk("rst_busy", {31'd0, busy},         32'd0);
        chk("rst_done", {31'd0, done},         32'd0);
        RESETn = 1'b1;
        cyc(2);

        // 1: single word, fastest SCK
        clk_div = 8'd0;
        mon_clear();
        push(8'hA5);
        en = 1'b1;
        wait_idle("t1_idle", 100);
        cyc(2);
        chk("t1_reads",  mon_reads,         32'd1);
        chk("t1_cs_low", mon_cs_low,        32'd17);
        chk("t1_rises",  mon_rises,         32'd8);
        chk("t1_bits",   {24'd0, mon_bits[7:0]}, 32'hA5);
        chk("t1_done",   mon_done,          32'd1);
        chk("t1_busy",   mon_busy,          32'd19);

        // 2: H=4, divider rewritten mid-word
        clk_div = 8'd3;
        mon_clear();
        push(8'h3C);
        cyc(20);
        clk_div = 8'd0;
        wait_idle("t2_idle", 400);
        cyc(2);
        chk("t2_cs_low", mon_cs_low,        32'd68);
        chk("t2_sck_hi", mon_sck_hi,        32'd32);
        chk("t2_rises",  mon_rises,         32'd8);
        chk("t2_bits",   {24'd0, mon_bits[7:0]}, 32'h3C);
        chk("t2_done",   mon_done,          32'd1);

        // 3: enabled with an empty FIFO
        mon_clear();
        cyc(100);
        chk("t3_reads",  mon_reads,  32'd0);
        chk("t3_busy",   mon_busy,   32'd0);
        chk("t3_done",   mon_done,   32'd0);
        chk("t3_cs_low", mon_cs_low, 32'd0);

        // 4: three queued words
        en = 1'b0;
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        cyc(1);
        mon_clear();
        en = 1'b1;
        wait_idle("t4_idle", 300);
        cyc(2);
        chk("t4_reads", mon_reads,           32'd3);
        chk("t4_done",  mon_done,            32'd3);
        chk("t4_rises", mon_rises,           32'd24);
        chk("t4_bits",  {8'd0, mon_bits[23:0]}, 32'h0180FF);
`ifdef SPI_TX_BURST_EN
        chk("t4_windows", mon_cs_win, 32'd1);
        chk("t4_cs_low",  mon_cs_low, 32'd49);
`else
        chk("t4_windows", mon_cs_win, 32'd3);
        chk("t4_cs_low",  mon_cs_low, 32'd51);
`endif

        // 5: asynchronous reset during bit 4 of 8'hF0
        en = 1'b0;
        clk_div = 8'd1;
        push(8'hF0);
        push(8'h5A);
        cyc(1);
        mon_clear();
        en = 1'b1;
        wait_rises("t5_reach_bit4", 4, 200);
        chk("t5_cs_before", {31'd0, CS_n}, 32'd0);
        #2;
        RESETn = 1'b0;
        #1;
        chk("t5_rst_read", {31'd0, fifo_tx_read}, 32'd0);
        chk("t5_rst_sck",  {31'd0, SCK},          32'd0);
        chk("t5_rst_mosi", {31'd0, MOSI},         32'd0);
        chk("t5_rst_cs_n", {31'd0, CS_n},         32'd1);
        chk("t5_rst_busy", {31'd0, busy},         32'd0);
        chk("t5_rst_done", {31'd0, done},         32'd0);
        cyc(3);
        mon_clear();
        RESETn = 1'b1;
        wait_idle("t5_idle", 200);
        cyc(2);
        chk("t5_reads", mon_reads,           32'd1);
        chk("t5_rises", mon_rises,           32'd8);
        chk("t5_bits",  {24'd0, mon_bits[7:0]}, 32'h5A);
        chk("t5_done",  mon_done,            32'd1);
        chk("t5_fifo",  fifo_q.size(),       32'd0);

        // 6: en dropped during bit 2 with two words queued
        en = 1'b0;
        clk_div = 8'd0;
        push(8'h11);
        push(8'h22);
        cyc(1);
        mon_clear();
        en = 1'b1;
        wait_rises("t6_reach_bit2", 2, 100);
        en = 1'b0;
        wait_idle("t6_idle", 100);
        cyc(5);
        chk("t6_reads", mon_reads,           32'd1);
        chk("t6_done",  mon_done,            32'd1);
        chk("t6_bits",  {24'd0, mon_bits[7:0]}, 32'h11);
        chk("t6_fifo",  fifo_q.size(),       32'd1);

        en = 1'b1;
        wait_idle("flush_idle", 100);
        en = 1'b0;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
